// File: rtl/skid_pkg.sv
// Shared types and constants for the skid buffer register slice.
package skid_pkg;

    // Occupancy state of the two-entry slice.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    localparam int LEVEL_W = 2;

endpackage : skid_pkg

// File: rtl/dflipflop.sv
// Enabled data register with synchronous active-low clear.
// Holds its value whenever en is low.
module dflipflop #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [size-1:0] d,
    output logic [size-1:0] q
);

    logic [size-1:0] q_reg;

    // Clear on reset, load on enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : dflipflop

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice. All outputs are decoded from
// registered state, so ready does not ripple combinationally upstream.
module skid_buffer
    import skid_pkg::*;
#(
    parameter int size = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [size-1:0]    s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [size-1:0]    m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [LEVEL_W-1:0] level
);

    skid_state_t     state_reg;
    skid_state_t     state_next;
    logic            main_load;
    logic            skid_load;
    logic [size-1:0] main_d;
    logic [size-1:0] main_q;
    logic [size-1:0] skid_q;

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and register load strobes.
    always_comb begin
        state_next = EMPTY;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        case (state_reg)
            EMPTY: begin
                state_next = s_valid ? BUSY : EMPTY;
                main_load  = s_valid;
            end
            BUSY: begin
                state_next = BUSY;
                if (s_valid && m_ready) begin
                    main_load = 1'b1;
                end else if (s_valid) begin
                    skid_load  = 1'b1;
                    state_next = FULL;
                end else if (m_ready) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // Input is not accepted here; only the consumer can make room.
                state_next = m_ready ? BUSY : FULL;
                main_load  = m_ready;
            end
            default: begin
                // Unreachable encoding recovers to EMPTY without loading data.
                state_next = EMPTY;
            end
        endcase
    end

    // Main register refills from the older skid entry when draining FULL.
    assign main_d = (state_reg == FULL) ? skid_q : s_data;

    dflipflop #(.size(size)) u_main_reg (
        .clk (clk),
        .rst (rst),
        .en  (main_load),
        .d   (main_d),
        .q   (main_q)
    );

    dflipflop #(.size(size)) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .en  (skid_load),
        .d   (s_data),
        .q   (skid_q)
    );

    // Output decode purely from the registered state.
    always_comb begin
        m_valid = 1'b0;
        s_ready = 1'b1;
        level   = '0;
        case (state_reg)
            BUSY: begin
                m_valid = 1'b1;
                level   = LEVEL_W'(1);
            end
            FULL: begin
                m_valid = 1'b1;
                s_ready = 1'b0;
                level   = LEVEL_W'(2);
            end
            default: begin
                m_valid = 1'b0;
                s_ready = 1'b1;
                level   = '0;
            end
        endcase
    end

    assign m_data = main_q;

endmodule : skid_buffer

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: a FIFO-of-depth-2 reference model,
// a per-cycle compare process, directed scenarios and a random phase.
module tb_skid_buffer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [1:0]   level;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    logic [W-1:0] model_q[$];

    skid_buffer #(.size(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue of capacity 2, updated from the
    // values seen at the clock edge (pop by the consumer, then push).
    always @(posedge clk) begin
        int sz;
        sz = model_q.size();
        if (!rst) begin
            model_q.delete();
        end else begin
            if (sz > 0 && m_ready) begin
                $display("[TB] out beat %02h", model_q[0]);
                void'(model_q.pop_front());
            end
            if (s_valid && sz < 2) begin
                model_q.push_back(s_data);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            int sz;
            sz = model_q.size();
            tests++;
            if (m_valid !== (sz > 0)) begin
                fails++;
                $display("FAIL m_valid: got %0b want %0b", m_valid, sz > 0);
            end
            tests++;
            if (s_ready !== (sz < 2)) begin
                fails++;
                $display("FAIL s_ready: got %0b want %0b", s_ready, sz < 2);
            end
            tests++;
            if (level !== 2'(sz)) begin
                fails++;
                $display("FAIL level: got %0d want %0d", level, sz);
            end
            if (sz > 0) begin
                tests++;
                if (m_data !== model_q[0]) begin
                    fails++;
                    $display("FAIL m_data: got %02h want %02h", m_data, model_q[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        m_ready = 1'b1;
        step();
        step();
        chk("reset m_valid", W'(m_valid), 8'h00);
        chk("reset s_ready", W'(s_ready), 8'h01);
        chk("reset level",   W'(level),   8'h00);
        chk("reset m_data",  m_data,      8'h00);
        check_en = 1'b1;

        // First beat after release appears one cycle later.
        rst    = 1'b1;
        s_data = 8'hB1;
        step();
        chk("first beat data",  m_data,      8'hB1);
        chk("first beat valid", W'(m_valid), 8'h01);

        // Back-to-back streaming.
        for (int v = 1; v <= 16; v++) begin
            s_data = W'(v);
            step();
            chk("stream data",  m_data,      W'(v));
            chk("stream ready", W'(s_ready), 8'h01);
            chk("stream level", W'(level),   8'h01);
        end

        // Backpressure into FULL.
        s_data = 8'h11;
        step();
        s_data  = 8'h22;
        m_ready = 1'b0;
        step();
        chk("bp level",  W'(level),   8'h02);
        chk("bp ready",  W'(s_ready), 8'h00);
        chk("bp data",   m_data,      8'h11);

        // FULL hold while input toggles.
        for (int i = 0; i < 5; i++) begin
            s_data = W'($urandom);
            step();
            chk("hold data",  m_data,      8'h11);
            chk("hold level", W'(level),   8'h02);
            chk("hold valid", W'(m_valid), 8'h01);
        end

        // Release: 11 then 22 in order.
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk("pop1 data",  m_data,      8'h22);
        chk("pop1 ready", W'(s_ready), 8'h01);
        step();
        chk("pop2 valid", W'(m_valid), 8'h00);

        // Drain a single entry.
        s_valid = 1'b1;
        s_data  = 8'h33;
        m_ready = 1'b0;
        step();
        chk("drain data", m_data, 8'h33);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk("drain valid", W'(m_valid), 8'h00);
        chk("drain level", W'(level),   8'h00);

        // Reset while FULL discards both entries.
        s_valid = 1'b1;
        s_data  = 8'h44;
        m_ready = 1'b0;
        step();
        s_data = 8'h55;
        step();
        chk("pre-rst level", W'(level), 8'h02);
        rst = 1'b0;
        step();
        chk("mid-rst valid", W'(m_valid), 8'h00);
        chk("mid-rst ready", W'(s_ready), 8'h01);
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk("post-rst valid", W'(m_valid), 8'h00);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = W'($urandom);
            m_ready = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 60) != 0);
            step();
        end

        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_skid_buffer
